// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared types and helpers for the round-robin bus arbiter.
//   arb_state_e : 2-bit owner state (IDLE / OWN / TURN)
//   hold_cnt_w  : width of the hold counter for a given MAX_HOLD
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_TURN = 2'b10
  } arb_state_e;

  // clog2(MAX_HOLD+1), never narrower than one bit (MAX_HOLD = 0 means unlimited).
  function automatic int hold_cnt_w(input int max_hold);
    if (max_hold <= 0) return 1;
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_decoder.sv
// bus_arbiter_decoder
// Binary-to-one-hot decoder with enable.
//   S  : binary select
//   EN : output enable; Y is all-zero when low
//   Y  : one-hot output
module bus_arbiter_decoder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]    S,
  input  logic                EN,
  output logic [2**WIDTH-1:0] Y
);

  always_comb begin
    Y = '0;
    if (EN) Y[S] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick
// Combinational rotate-priority finder: returns the first asserted request
// searching PTR, PTR+1, ... modulo 2**WIDTH.
//   REQ   : request vector
//   PTR   : index with highest priority
//   IDX   : winning index (valid only when VALID)
//   VALID : at least one request asserted
module bus_arbiter_rr_pick #(
  parameter int WIDTH = 3
) (
  input  logic [2**WIDTH-1:0] REQ,
  input  logic [WIDTH-1:0]    PTR,
  output logic [WIDTH-1:0]    IDX,
  output logic                VALID
);

  localparam int N = 2**WIDTH;

  logic [WIDTH-1:0] cand;

  always_comb begin
    IDX   = PTR;
    VALID = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // Natural WIDTH-bit overflow gives the N-1 -> 0 wrap.
      cand = PTR + WIDTH'(i);
      if (!VALID && REQ[cand]) begin
        IDX   = cand;
        VALID = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter for one shared internal bus with a one-cycle turnaround
// gap between owners and an optional maximum hold time.
//   CLK     : rising-edge clock
//   RST_N   : asynchronous active-low reset
//   REQ     : level request per requester, held until done
//   GNT     : one-hot grant, all-zero when no owner
//   GNT_IDX : index of current or last owner
//   BUSY    : high while a grant is active
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [2**WIDTH-1:0] REQ,
  output logic [2**WIDTH-1:0] GNT,
  output logic [WIDTH-1:0]    GNT_IDX,
  output logic                BUSY
);

  localparam int                HOLD_W   = hold_cnt_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_e        state_q, state_d;
  logic [WIDTH-1:0]  gnt_idx_q, gnt_idx_d;
  logic [WIDTH-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [WIDTH-1:0]  pick_idx;
  logic              pick_vld;
  logic              hold_limit;
  logic              others_waiting;

  bus_arbiter_rr_pick #(.WIDTH(WIDTH)) u_pick (
    .REQ   (REQ),
    .PTR   (ptr_q),
    .IDX   (pick_idx),
    .VALID (pick_vld)
  );

  bus_arbiter_decoder #(.WIDTH(WIDTH)) u_dec (
    .S  (gnt_idx_q),
    .EN (state_q == ST_OWN),
    .Y  (GNT)
  );

  assign GNT_IDX = gnt_idx_q;
  assign BUSY    = (state_q == ST_OWN);

  // GNT is the owner's one-hot bit while in OWN, so masking it out of REQ
  // leaves exactly the competing requesters.
  assign others_waiting = |(REQ & ~GNT);
  assign hold_limit     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX);

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (pick_vld) begin
          state_d    = ST_OWN;
          gnt_idx_d  = pick_idx;
          hold_cnt_d = HOLD_ONE;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (!REQ[gnt_idx_q] || (hold_limit && others_waiting)) begin
          // Leaving the bus: the old owner becomes lowest priority.
          state_d = ST_TURN;
          ptr_d   = gnt_idx_q + WIDTH'(1);
        end else if ((MAX_HOLD != 0) && !hold_limit) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n, rst0_n;
  logic [3:0] req, req0;
  logic [3:0] gnt, gnt0;
  logic [1:0] gnt_idx, gnt_idx0;
  logic       busy, busy0;

  int checks;
  int failures;

  bus_arbiter #(.WIDTH(2), .MAX_HOLD(4)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .REQ     (req),
    .GNT     (gnt),
    .GNT_IDX (gnt_idx),
    .BUSY    (busy)
  );

  bus_arbiter #(.WIDTH(2), .MAX_HOLD(0)) dut0 (
    .CLK     (clk),
    .RST_N   (rst0_n),
    .REQ     (req0),
    .GNT     (gnt0),
    .GNT_IDX (gnt_idx0),
    .BUSY    (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rst0_n   = 1'b0;
    req      = 4'b1111;
    req0     = 4'b0000;

    // 1: reset state with all requests asserted, no edge yet
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", gnt_idx, 2'd0);
    step();
    step();
    chk("rst_hold_gnt", gnt, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b0100;
    step();
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_idx", gnt_idx, 2'd2);
    chk("t1_busy", busy, 1'b1);
    req = 4'b0000;
    step();
    chk("t1_turn_gnt", gnt, 4'b0000);
    chk("t1_turn_busy", busy, 1'b0);
    chk("t1_turn_idx", gnt_idx, 2'd2);
    step();
    chk("t1_idle_gnt", gnt, 4'b0000);

    // 2: all requesting, forced rotation 0,1,2,3,0 with turnaround gaps
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("t2_own%0d_c%0d", k, c), gnt, 4'b0001 << (k % 4));
      end
      step();
      chk($sformatf("t2_turn%0d", k), gnt, 4'b0000);
      chk($sformatf("t2_turn%0d_busy", k), busy, 1'b0);
    end
    req = 4'b0000;
    step();
    chk("t2_idle_gnt", gnt, 4'b0000);

    // 3: single requester saturates hold without rotating
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("t3_hold_c%0d", c), gnt, 4'b0010);
    end
    req = 4'b0000;
    step();
    chk("t3_turn_gnt", gnt, 4'b0000);
    chk("t3_turn_busy", busy, 1'b0);
    chk("t3_turn_idx", gnt_idx, 2'd1);
    step();
    chk("t3_idle_gnt", gnt, 4'b0000);
    chk("t3_idle_idx", gnt_idx, 2'd1);

    // 4: owner 3 releases with 0 and 1 pending; pointer wraps to 0
    req = 4'b1000;
    step();
    chk("t4_own3_gnt", gnt, 4'b1000);
    chk("t4_own3_idx", gnt_idx, 2'd3);
    req = 4'b1011;
    step();
    chk("t4_own3_keep", gnt, 4'b1000);
    req = 4'b0011;
    step();
    chk("t4_turn_gnt", gnt, 4'b0000);
    step();
    chk("t4_wrap_gnt", gnt, 4'b0001);
    chk("t4_wrap_idx", gnt_idx, 2'd0);

    // 5: asynchronous reset in the middle of a grant
    req = 4'b0010;
    step();
    chk("t5_turn_gnt", gnt, 4'b0000);
    step();
    chk("t5_own1_gnt", gnt, 4'b0010);
    chk("t5_own1_idx", gnt_idx, 2'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", gnt, 4'b0000);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_idx", gnt_idx, 2'd0);
    req = 4'b1000;
    step();
    chk("t5_inrst_gnt", gnt, 4'b0000);
    rst_n = 1'b1;
    step();
    chk("t5_post_gnt", gnt, 4'b1000);
    chk("t5_post_idx", gnt_idx, 2'd3);
    chk("t5_post_busy", busy, 1'b1);

    // 6: unlimited hold keeps owner 0 until it releases
    rst0_n = 1'b1;
    req0   = 4'b0011;
    for (int c = 0; c < 50; c++) begin
      step();
      chk($sformatf("t6_hold_c%0d", c), gnt0, 4'b0001);
    end
    req0 = 4'b0010;
    step();
    chk("t6_turn_gnt", gnt0, 4'b0000);
    chk("t6_turn_busy", busy0, 1'b0);
    step();
    chk("t6_own1_gnt", gnt0, 4'b0010);
    chk("t6_own1_idx", gnt_idx0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
